mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 14 +
 rtl/mul_seq_adder.sv | 18 +
 rtl/mul_seq.sv | 115 +++++++++++
 tb/tb_mul_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
//   state_e      : controller states (idle / running / result held)
//   DefaultWidth : default operand width in bits
package mul_seq_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_adder.sv
// Parameterised ripple-style adder used by the multiplier's add path.
//   i_a, i_b : W-bit addends
//   i_cin    : carry in
//   o_sum    : W-bit sum
//   o_cout   : carry out
module mul_seq_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier, one shift-and-add step per clock.
// An operand pair is taken on i_valid && o_ready, the product appears N cycles later
// and is held on o_p with o_valid high until the consumer asserts i_ready.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_valid, o_ready : operand handshake (accepted only in idle)
//   i_a, i_b         : N-bit unsigned multiplicand / multiplier
//   o_valid, i_ready : product handshake
//   o_p              : 2N-bit product, zero unless o_valid
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_p
);

  localparam int unsigned CntW = $clog2(N) + 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    w_a_nxt;
  logic [N-1:0]    r_b;
  logic [N-1:0]    w_b_nxt;
  logic [2*N-1:0]  r_acc;
  logic [2*N-1:0]  w_acc_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  logic [N-1:0]    w_addend;
  logic [N-1:0]    w_sum;
  logic            w_cout;

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_b[0] ? r_a : '0;

  mul_seq_adder #(
    .W (N)
  ) u_adder (
    .i_a    (r_acc[2*N-1:N]),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_p         = '0;

    unique case (r_state)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_a_nxt     = i_a;
          w_b_nxt     = i_b;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        // Carry out becomes the new MSB; the partial product slides right one place.
        w_acc_nxt = {w_cout, w_sum, r_acc[N-1:1]};
        w_b_nxt   = r_b >> 1;
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntW'(N - 1)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_valid = 1'b1;
        o_p     = r_acc;
        // Return through idle so a new pair cannot be taken on the handshake edge.
        if (i_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq (N = 8). Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_mul_seq;

  localparam int unsigned N = 8;

  logic           clk;
  logic           rst;
  logic           i_valid;
  logic           o_ready;
  logic [N-1:0]   i_a;
  logic [N-1:0]   i_b;
  logic           o_valid;
  logic           i_ready;
  logic [2*N-1:0] o_p;

  int checks = 0;
  int errors = 0;

  mul_seq #(
    .N (N)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_p     (o_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call at the falling edge after an accept; returns edges from accept to o_valid (capped at 20).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: ready=%b valid=%b p=%h want 1 0 0000", o_ready, o_valid, o_p);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b p=%h want 1 0 0000", o_ready, o_valid, o_p);
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp);
    int lat;
    i_a = a; i_b = b; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0 || o_p !== 16'h0000) begin
      errors++;
      $display("FAIL %s_run: ready=%b p=%h want 0 0000", name, o_ready, o_p);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 8", name, lat);
    end
    checks++;
    if (o_p !== exp) begin
      errors++;
      $display("FAIL %s_product: got %h want %h", name, o_p, exp);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_p !== 16'h0000) begin
      errors++;
      $display("FAIL %s_handshake: valid=%b ready=%b p=%h want 0 1 0000", name, o_valid, o_ready,
               o_p);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    i_a = 8'h0F; i_b = 8'h10; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 8", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_p !== 16'h00F0 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b p=%h ready=%b want 1 00f0 0", i, o_valid, o_p,
                 o_ready);
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_disturb;
    int lat;
    i_a = 8'h12; i_b = 8'h34; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!o_valid && lat < 20) begin
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL disturb_ready%0d: got %b want 0", lat, o_ready);
      end
      i_a = 8'($urandom); i_b = 8'($urandom); i_valid = ~i_valid;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 8 || o_p !== 16'h03A8) begin
      errors++;
      $display("FAIL disturb_product: lat=%0d p=%h want 8 03a8", lat, o_p);
    end
    i_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat;
    i_a = 8'h77; i_b = 8'h99; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_p !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: valid=%b ready=%b p=%h want 0 1 0000", o_valid, o_ready, o_p);
    end
    @(negedge clk);
    rst = 1'b0;
    i_a = 8'h03; i_b = 8'h05; i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_accept: ready=%b want 0", o_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8 || o_p !== 16'h000F) begin
      errors++;
      $display("FAIL rst_next_op: lat=%0d p=%h want 8 000f", lat, o_p);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] vp [3];
    int lat;
    va[0] = 8'h11; vb[0] = 8'h22; vp[0] = 16'h0242;
    va[1] = 8'hFF; vb[1] = 8'h01; vp[1] = 16'h00FF;
    va[2] = 8'h80; vb[2] = 8'h80; vp[2] = 16'h4000;
    i_a = va[0]; i_b = vb[0]; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_accept%0d: ready=%b want 0", k, o_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat !== 8 || o_p !== vp[k]) begin
        errors++;
        $display("FAIL b2b_product%0d: lat=%0d p=%h want 8 %h", k, lat, o_p, vp[k]);
      end
      if (k < 2) begin
        i_a = va[k+1]; i_b = vb[k+1];
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle%0d: ready=%b valid=%b want 1 0", k, o_ready, o_valid);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: ready=%b valid=%b want 1 0", o_ready, o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single("zero", 8'h00, 8'h00, 16'h0000);
    test_single("max_ff", 8'hFF, 8'hFF, 16'hFE01);
    test_single("max_bd", 8'hBD, 8'hA5, 16'h79D1);
    test_backpressure();
    test_disturb();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
